seq_shift_divider: RTL and testbench
====================================

Name: seq_shift_divider

Overview:
- Multi-cycle unsigned integer divider built on a 1-bit shift/compare/subtract datapath (restoring algorithm). Produces one quotient bit per clock.
- Sits beside the fixed shift-by-one datapath blocks. Used wherever division by a non-constant divisor is needed and a combinational divider is too large.
- Valid/ready handshake on both input and output sides.

Parameters:
- N, 8, operand width in bits (dividend, divisor, quotient, remainder); legal range 2..32.

Ports:
- clk  input  1  clock, rising edge
- rstN  input  1  asynchronous reset, active low
- in_valid  input  1  dividend/divisor valid
- in_ready  output  1  block can accept an operation
- dividend  input  N  unsigned dividend
- divisor  input  N  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quotient  output  N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  flag: divisor was zero

Behaviour:
- Interface: one clock (clk); reset rstN is asynchronous, active-low. All outputs are registered.
- Reset values: in_ready=0 while rstN low, then 1 (IDLE); out_valid=0; quotient=0; remainder=0; div_by_zero=0; FSM=IDLE; counter=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&&in_ready at edge T. Capture dividend and divisor.
  - divisor==0 -> DONE.
  - Otherwise -> CALC, with counter=N-1, partial remainder=0, quotient register=dividend.
- CALC:
  - in_ready=0. Each cycle: shift {rem,quo} left by 1; rem is N+1 bits wide.
  - If rem>=divisor: rem-=divisor, quo[0]=1; else quo[0]=0.
  - counter decrements each cycle; on counter==0 -> DONE.
  - Exactly N cycles in CALC.
- DONE:
  - out_valid=1, results loaded on the DONE-entry edge.
  - Normal latency: out_valid first high at T+N+1.
  - Divide-by-zero latency: out_valid high at T+1, with quotient={N{1}}, remainder=dividend, div_by_zero=1.
  - quotient, remainder and div_by_zero hold stable while out_valid&&!out_ready (backpressure, unbounded).
  - On out_valid&&out_ready: out_valid=0 next cycle and FSM -> IDLE (in_ready=1 next cycle).
  - Throughput: one operation per N+2 cycles at best.
- in_valid is ignored outside IDLE. dividend and divisor may change freely after the accept edge.
- div_by_zero is cleared when the next operation is accepted.
- Boundary cases:
  - dividend<divisor -> quotient=0, remainder=dividend.
  - divisor==1 -> quotient=dividend, remainder=0.
  - dividend==0 -> quotient=0, remainder=0.
  - max/max -> quotient=1, remainder=0.
- Reset mid-operation (rstN low in CALC or DONE): immediate return to reset values; the in-flight result is discarded and no out_valid is produced.
- Arithmetic: the comparison uses the N+1-bit partial remainder, so no overflow for any divisor up to 2^N-1. The final remainder is truncated to N bits; the upper bit is always 0.

Optional Feature:
- Macro: SEQ_SHIFT_DIVIDER_POW2_FAST_EN.
- Defined: in IDLE, if divisor has exactly one bit set (bit k), bypass CALC and go directly to DONE.
  - quotient = dividend >> k; remainder = dividend & (divisor-1); div_by_zero=0.
  - out_valid at T+1.
  - Uses a priority encoder and a barrel right shift.
- Undefined: powers of two take the normal N-cycle CALC path; results are identical, only latency differs.

Test Plan:
- N=8, accept 100/7 at T, out_ready=1 -> out_valid at T+9, quotient=14, remainder=2, div_by_zero=0; in_ready=1 at T+10.
- 255/1 -> quotient=255, remainder=0; and 3/200 -> quotient=0, remainder=3; and 255/255 -> quotient=1, remainder=0.
- 5/0 -> out_valid at T+1, quotient=255, remainder=5, div_by_zero=1; next op 9/3 -> quotient=3, remainder=0, div_by_zero=0.
- 200/9 with out_ready held low 6 cycles after out_valid -> quotient=22, remainder=2 held stable throughout; in_valid pulses during CALC/DONE ignored; in_ready stays 0.
- rstN low for 1 cycle 4 cycles into CALC of 77/5 -> all outputs reset, no out_valid; a following op 77/5 -> quotient=15, remainder=2 at T'+9.
- With SEQ_SHIFT_DIVIDER_POW2_FAST_EN: 200/8 -> out_valid at T+1, quotient=25, remainder=0; 201/16 -> quotient=12, remainder=9. Without the macro: same values at T+9.

Source files
------------

// File: rtl/seq_shift_divider.sv
// seq_shift_divider
//   Multi-cycle unsigned divider using the restoring shift/compare/subtract
//   algorithm, one quotient bit per clock. Valid/ready handshake on both the
//   operand side and the result side. All outputs are registered.
//
//   Optional build macro: SEQ_SHIFT_DIVIDER_POW2_FAST_EN
//     When defined, a divisor that is an exact power of two bypasses the
//     iterative path and the result is ready one cycle after acceptance.
//
//   Parameters
//     N            operand width in bits (2..32)
//
//   Ports
//     clk          clock, rising edge
//     rstN         asynchronous reset, active low
//     in_valid     dividend/divisor valid
//     in_ready     block can accept an operation (high only in IDLE)
//     dividend     unsigned dividend
//     divisor      unsigned divisor
//     out_valid    result valid (held until out_ready)
//     out_ready    consumer accepts result
//     quotient     unsigned quotient
//     remainder    unsigned remainder
//     div_by_zero  divisor of the current result was zero
module seq_shift_divider #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rstN,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int unsigned    CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0]  CNT_INIT = CW'(N - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q,       state_d;
   logic [CW-1:0]  cnt_q,         cnt_d;
   logic [N-1:0]   rem_q,         rem_d;
   logic [N-1:0]   quo_q,         quo_d;
   logic [N-1:0]   dvsr_q,        dvsr_d;
   logic           in_ready_q,    in_ready_d;
   logic           out_valid_q,   out_valid_d;
   logic [N-1:0]   quotient_q,    quotient_d;
   logic [N-1:0]   remainder_q,   remainder_d;
   logic           dbz_q,         dbz_d;

   logic           accept;

   // One restoring-division step. The shifted partial remainder is N+1 bits
   // so the compare cannot overflow for any divisor up to 2^N-1; after the
   // conditional subtract it is always below the divisor, so N bits are
   // enough to hold it between steps.
   logic [N:0]     rem_shift;
   logic           fits;
   logic [N-1:0]   rem_step;
   logic [N-1:0]   quo_step;

   always_comb begin
      rem_shift = {rem_q, quo_q[N-1]};
      fits      = (rem_shift >= {1'b0, dvsr_q});
      rem_step  = N'(fits ? (rem_shift - {1'b0, dvsr_q}) : rem_shift);
      quo_step  = {quo_q[N-2:0], fits};
   end

`ifdef SEQ_SHIFT_DIVIDER_POW2_FAST_EN
   localparam logic [N-1:0] ONE_N = N'(1);

   logic           is_pow2;
   logic [CW-1:0]  pow2_shamt;
   logic [N-1:0]   pow2_mask;

   // Priority encoder: position of the (single) set bit of the divisor.
   always_comb begin
      pow2_shamt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (divisor[i]) begin
            pow2_shamt = CW'(i);
         end
      end
   end

   always_comb begin
      pow2_mask = divisor - ONE_N;
      is_pow2   = (divisor != '0) && ((divisor & pow2_mask) == '0);
   end
`endif

   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvsr_d      = dvsr_q;
      out_valid_d = out_valid_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               dvsr_d = divisor;
               dbz_d  = 1'b0;
               if (divisor == '0) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end
`ifdef SEQ_SHIFT_DIVIDER_POW2_FAST_EN
               else if (is_pow2) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  quotient_d  = dividend >> pow2_shamt;
                  remainder_d = dividend & pow2_mask;
               end
`endif
               else begin
                  state_d = CALC;
                  cnt_d   = CNT_INIT;
                  rem_d   = '0;
                  quo_d   = dividend;
               end
            end
         end

         CALC: begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CNT_ONE;
            // The last step's result goes straight into the output
            // registers so out_valid rises on the same edge.
            if (cnt_q == '0) begin
               state_d     = DONE;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               quotient_d  = quo_step;
               remainder_d = rem_step;
            end
         end

         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end

         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvsr_q      <= dvsr_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_shift_divider.sv
// tb_seq_shift_divider
//   Self-checking bench for seq_shift_divider (N=8). Directed boundary cases
//   followed by randomized operations, checked against plain arithmetic.
module tb_seq_shift_divider;

   localparam int unsigned N = 8;

   logic         clk;
   logic         rstN;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   int unsigned  n_checks;
   int unsigned  n_fail;

   seq_shift_divider #(.N(N)) dut (
      .clk         (clk),
      .rstN        (rstN),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: plain arithmetic on the specification's rules.
   // Latency is counted as in the spec: 1 = first cycle after the accept edge.
   task automatic model(input int unsigned a, input int unsigned b,
                        output int unsigned q, output int unsigned r,
                        output int unsigned dz, output int unsigned lat);
      if (b == 0) begin
         q   = (1 << N) - 1;
         r   = a;
         dz  = 1;
         lat = 1;
      end else begin
         q   = a / b;
         r   = a % b;
         dz  = 0;
         lat = N + 1;
`ifdef SEQ_SHIFT_DIVIDER_POW2_FAST_EN
         if ((b & (b - 1)) == 0) lat = 1;
`endif
      end
   endtask

   // Entered and left at a sample point (#1 after a rising edge).
   task automatic run_op(input int unsigned a, input int unsigned b,
                         input int unsigned hold, input bit junk);
      int unsigned eq, er, edz, elat, lat;
      bit          seen;
      model(a, b, eq, er, edz, elat);

      seen = 1'b0;
      for (int i = 0; i < 4 * N; i++) begin
         if (in_ready) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!seen) begin
         check("idle_in_ready", 32'(in_ready), 32'd1);
         return;
      end

      @(negedge clk);
      in_valid = 1'b1;
      dividend = N'(a);
      divisor  = N'(b);
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = N'($urandom);
      divisor  = N'($urandom);

      lat  = 1;
      seen = 1'b0;
      for (int i = 0; i < 4 * N; i++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         check("busy_in_ready", 32'(in_ready), 32'd0);
         check("busy_dbz_cleared", 32'(div_by_zero), 32'd0);
         if (junk) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            dividend = N'($urandom);
            divisor  = N'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      if (!seen) begin
         check("out_valid_timeout", 32'(out_valid), 32'd1);
         in_valid = 1'b0;
         return;
      end

      check("latency",     lat,              elat);
      check("quotient",    32'(quotient),    eq);
      check("remainder",   32'(remainder),   er);
      check("div_by_zero", 32'(div_by_zero), edz);
      check("done_in_ready", 32'(in_ready),  32'd0);

      for (int unsigned h = 0; h < hold; h++) begin
         @(negedge clk);
         if (junk) in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         check("hold_out_valid", 32'(out_valid),   32'd1);
         check("hold_quotient",  32'(quotient),    eq);
         check("hold_remainder", 32'(remainder),   er);
         check("hold_dbz",       32'(div_by_zero), edz);
         check("hold_in_ready",  32'(in_ready),    32'd0);
      end

      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_hs_out_valid", 32'(out_valid), 32'd0);
      check("post_hs_in_ready",  32'(in_ready),  32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a, b, sel;
      n_checks  = 0;
      n_fail    = 0;
      rstN      = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;

      #12;
      check("rst_in_ready",  32'(in_ready),    32'd0);
      check("rst_out_valid", 32'(out_valid),   32'd0);
      check("rst_quotient",  32'(quotient),    32'd0);
      check("rst_remainder", 32'(remainder),   32'd0);
      check("rst_dbz",       32'(div_by_zero), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk); #1;
      check("idle_after_rst", 32'(in_ready), 32'd1);

      run_op(100, 7,   0, 1'b0);
      run_op(255, 1,   0, 1'b0);
      run_op(3,   200, 0, 1'b0);
      run_op(255, 255, 0, 1'b0);
      run_op(0,   37,  1, 1'b0);
      run_op(5,   0,   2, 1'b0);
      run_op(9,   3,   0, 1'b0);
      run_op(200, 9,   6, 1'b1);

      // Reset four cycles into CALC: result must be dropped.
      @(negedge clk);
      in_valid = 1'b1;
      dividend = N'(77);
      divisor  = N'(5);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rstN = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid),   32'd0);
      check("midrst_in_ready",  32'(in_ready),    32'd0);
      check("midrst_quotient",  32'(quotient),    32'd0);
      check("midrst_remainder", 32'(remainder),   32'd0);
      check("midrst_dbz",       32'(div_by_zero), 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      for (int i = 0; i < 2 * N; i++) begin
         @(posedge clk); #1;
         check("midrst_no_result", 32'(out_valid), 32'd0);
      end
      run_op(77, 5, 0, 1'b0);

      run_op(200, 8,  0, 1'b0);
      run_op(201, 16, 1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         sel = $urandom_range(0, 9);
         a   = (sel == 9) ? 255 : $urandom_range(0, 255);
         if (sel == 0)      b = 0;
         else if (sel <= 2) b = 1 << $urandom_range(0, N - 1);
         else               b = $urandom_range(1, 255);
         run_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
